// File: rtl/imem_line_server_pkg.sv
// Shared constants, FSM encoding and address helper for the instruction line server.
package imem_line_server_pkg;

  localparam int ADDR_LEN        = 32;
  localparam int INSN_LEN        = 32;
  localparam int IMEM_LINE_BYTES = 16;
  localparam int IMEM_BEATS      = 4;

  typedef enum logic {
    IMEM_IDLE = 1'b0,
    IMEM_FILL = 1'b1
  } imem_state_e;

  // Word address of one beat within a line: {line, beat, byte offset 0}.
  function automatic logic [ADDR_LEN-1:0] beat_addr(input logic [ADDR_LEN-5:0] line,
                                                    input logic [1:0] beat);
    return {line, beat, 2'b00};
  endfunction

endpackage

// File: rtl/imem_line_store.sv
// Direct-mapped line storage: LINES x (tag, 128-bit data) with per-line valid bits,
// a combinational lookup port, one write port and a clear-all of the valid bits.
module imem_line_store
  import imem_line_server_pkg::*;
#(
  parameter int LINES = 4,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = ADDR_LEN - 4 - IDX_W
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic [IDX_W-1:0]      rd_idx,
  input  logic [TAG_W-1:0]      rd_tag,
  output logic                  rd_hit,
  output logic [4*INSN_LEN-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [4*INSN_LEN-1:0] wr_data,
  input  logic                  wr_valid
);

  logic [LINES-1:0]      valid_reg;
  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [4*INSN_LEN-1:0] data_mem [LINES];

  // Clear-all takes priority so a flush on the completing write leaves the line invalid.
  always_ff @(posedge clk) begin
    if (clear) begin
      valid_reg <= '0;
    end else if (wr_en) begin
      valid_reg[wr_idx] <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_hit  = valid_reg[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/imem_line_server.sv
// Fetch-side line server: same-cycle hits from a direct-mapped line buffer, 4-beat refill
// over a 32-bit req/ack bus on a miss. Optional hit/miss counters under IMEM_STATS_EN.
module imem_line_server
  import imem_line_server_pkg::*;
#(
  parameter int LINES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_LEN-1:0]   pc,
  input  logic                  flush,
  output logic [4*INSN_LEN-1:0] idata,
  output logic                  idata_valid,
  output logic                  stall,
  output logic                  mem_req,
  output logic [ADDR_LEN-1:0]   mem_addr,
  input  logic                  mem_ack,
  input  logic [INSN_LEN-1:0]   mem_rdata
`ifdef IMEM_STATS_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_LEN - 4 - IDX_W;

  imem_state_e           state_reg;
  logic [1:0]            beat_reg;
  logic [ADDR_LEN-5:0]   line_reg;
  logic                  kill_reg;
  logic [INSN_LEN-1:0]   word_reg [3];

  logic                  hit;
  logic [4*INSN_LEN-1:0] rd_data;
  logic [4*INSN_LEN-1:0] wr_data;
  logic                  wr_en;
  logic                  ack_ok;
  logic                  unused_pc_bits;

  assign unused_pc_bits = ^pc[3:0];
  assign ack_ok = mem_req && mem_ack;
  assign wr_en  = (state_reg == IMEM_FILL) && ack_ok && (beat_reg == 2'd3);

  // The last beat goes straight from the bus into the store, so only three words are held.
  for (genvar gi = 0; gi < IMEM_BEATS; gi++) begin : g_line
    if (gi == IMEM_BEATS - 1) begin : g_last
      assign wr_data[INSN_LEN*gi +: INSN_LEN] = mem_rdata;
    end else begin : g_held
      assign wr_data[INSN_LEN*gi +: INSN_LEN] = word_reg[gi];
    end
  end

  imem_line_store #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_store (
    .clk      (clk),
    .clear    (reset || flush),
    .rd_idx   (pc[4 +: IDX_W]),
    .rd_tag   (pc[ADDR_LEN-1:4+IDX_W]),
    .rd_hit   (hit),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (line_reg[IDX_W-1:0]),
    .wr_tag   (line_reg[ADDR_LEN-5:IDX_W]),
    .wr_data  (wr_data),
    .wr_valid (!kill_reg && !flush)
  );

  assign idata_valid = (state_reg == IMEM_IDLE) && hit && !reset;
  assign stall       = !idata_valid;
  assign idata       = idata_valid ? rd_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IMEM_IDLE;
      beat_reg  <= 2'd0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      kill_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IMEM_IDLE: begin
          if (!hit) begin
            state_reg <= IMEM_FILL;
            line_reg  <= pc[ADDR_LEN-1:4];
            beat_reg  <= 2'd0;
            mem_req   <= 1'b1;
            mem_addr  <= beat_addr(pc[ADDR_LEN-1:4], 2'd0);
            kill_reg  <= 1'b0;
          end
        end
        IMEM_FILL: begin
          // A flush mid-fill cannot abort the bus transfer; it only withholds validation.
          if (flush) kill_reg <= 1'b1;
          if (ack_ok) begin
            for (int i = 0; i < 3; i++) begin
              if (beat_reg == 2'(i)) word_reg[i] <= mem_rdata;
            end
            beat_reg <= beat_reg + 2'd1;
            mem_addr <= beat_addr(line_reg, beat_reg + 2'd1);
            if (beat_reg == 2'd3) begin
              state_reg <= IMEM_IDLE;
              mem_req   <= 1'b0;
              kill_reg  <= 1'b0;
            end
          end
        end
        default: state_reg <= IMEM_IDLE;
      endcase
    end
  end

`ifdef IMEM_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (idata_valid) hit_cnt <= hit_cnt + 32'd1;
      if ((state_reg == IMEM_IDLE) && !hit) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_line_server.sv
// Directed bench for imem_line_server: cold miss, hit, conflict, redirect, flush, reset mid-fill.
module tb_imem_line_server;
  import imem_line_server_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [ADDR_LEN-1:0]   pc;
  logic                  flush;
  logic [4*INSN_LEN-1:0] idata;
  logic                  idata_valid;
  logic                  stall;
  logic                  mem_req;
  logic [ADDR_LEN-1:0]   mem_addr;
  logic                  mem_ack;
  logic [INSN_LEN-1:0]   mem_rdata;
`ifdef IMEM_STATS_EN
  logic [31:0]           hit_cnt;
  logic [31:0]           miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_line_server #(.LINES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .flush       (flush),
    .idata       (idata),
    .idata_valid (idata_valid),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
`ifdef IMEM_STATS_EN
    ,
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
`endif
  );

  function automatic logic [31:0] dw(input logic [31:0] a);
    return 32'hA5A5_0000 | {16'h0000, a[15:0]};
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] base);
    return {dw(base + 32'd12), dw(base + 32'd8), dw(base + 32'd4), dw(base)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One beat: request seen, one idle cycle, then ack with data (optionally with flush).
  task automatic do_beat(input logic [31:0] addr, input logic fl);
    chk("fill_req", 128'(mem_req), 128'(1'b1));
    chk("fill_addr", 128'(mem_addr), 128'(addr));
    chk("fill_stall", 128'(stall), 128'(1'b1));
    tick();
    chk("hold_addr", 128'(mem_addr), 128'(addr));
    mem_ack   = 1'b1;
    mem_rdata = dw(addr);
    flush     = fl;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    flush     = 1'b0;
    $display("beat addr=%h flush=%0b", addr, fl);
  endtask

  task automatic start_miss(input logic [31:0] addr);
    pc = addr;
    settle();
    chk("miss_stall", 128'(stall), 128'(1'b1));
    chk("miss_valid", 128'(idata_valid), 128'(1'b0));
    chk("miss_idata", idata, 128'(0));
    tick();
  endtask

  task automatic fill_all(input logic [31:0] base);
    for (int b = 0; b < 4; b++) do_beat(base + 32'(4 * b), 1'b0);
  endtask

  task automatic expect_hit(input logic [31:0] base, input logic [31:0] pcv);
    pc = pcv;
    settle();
    chk("hit_valid", 128'(idata_valid), 128'(1'b1));
    chk("hit_idata", idata, line_of(base));
    chk("hit_stall", 128'(stall), 128'(1'b0));
    chk("hit_req", 128'(mem_req), 128'(1'b0));
    $display("hit pc=%h idata=%h", pcv, idata);
  endtask

  initial begin
    reset = 1'b1; pc = '0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    tick();
    tick();
    chk("rst_req", 128'(mem_req), 128'(1'b0));
    chk("rst_addr", 128'(mem_addr), 128'(0));
    chk("rst_idata", idata, 128'(0));
    chk("rst_valid", 128'(idata_valid), 128'(1'b0));
    chk("rst_stall", 128'(stall), 128'(1'b1));
`ifdef IMEM_STATS_EN
    chk("rst_hitcnt", 128'(hit_cnt), 128'(0));
    chk("rst_misscnt", 128'(miss_cnt), 128'(0));
`endif
    reset = 1'b0;

    // Cold miss then hit
    start_miss(32'h100);
    fill_all(32'h100);
    expect_hit(32'h100, 32'h100);

    // Hit on another word of the line; a stray ack while idle is ignored
    expect_hit(32'h100, 32'h108);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("stray_ack_req", 128'(mem_req), 128'(1'b0));
    expect_hit(32'h100, 32'h104);

    // Conflict on index 0
    start_miss(32'h140);
    fill_all(32'h140);
    expect_hit(32'h140, 32'h14C);
    start_miss(32'h100);
    fill_all(32'h100);
    expect_hit(32'h100, 32'h100);

    // Redirect mid-fill: 0x200 completes, then 0x300 fills
    start_miss(32'h200);
    do_beat(32'h200, 1'b0);
    do_beat(32'h204, 1'b0);
    pc = 32'h300;
    settle();
    chk("redirect_stall", 128'(stall), 128'(1'b1));
    do_beat(32'h208, 1'b0);
    do_beat(32'h20C, 1'b0);
    expect_hit(32'h200, 32'h200);
    start_miss(32'h300);
    fill_all(32'h300);
    expect_hit(32'h300, 32'h304);

    // Flush coincident with the last ack leaves the line invalid
    start_miss(32'h400);
    do_beat(32'h400, 1'b0);
    do_beat(32'h404, 1'b0);
    do_beat(32'h408, 1'b0);
    do_beat(32'h40C, 1'b1);
    start_miss(32'h400);
    fill_all(32'h400);
    expect_hit(32'h400, 32'h400);

    // Flush on a hit cycle: still valid that cycle, miss afterwards
    flush = 1'b1;
    settle();
    chk("flush_hit_valid", 128'(idata_valid), 128'(1'b1));
    tick();
    flush = 1'b0;
    start_miss(32'h400);

    // Reset after beat 2 abandons the fill
    do_beat(32'h400, 1'b0);
    do_beat(32'h404, 1'b0);
    do_beat(32'h408, 1'b0);
    reset = 1'b1;
    tick();
    chk("rst_fill_req", 128'(mem_req), 128'(1'b0));
    chk("rst_fill_addr", 128'(mem_addr), 128'(0));
`ifdef IMEM_STATS_EN
    chk("rst_fill_hitcnt", 128'(hit_cnt), 128'(0));
    chk("rst_fill_misscnt", 128'(miss_cnt), 128'(0));
`endif
    reset = 1'b0;
    start_miss(32'h100);
    do_beat(32'h100, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
